// File: rtl/lt_bank.sv
// Clock-synchronous bank of gated latches: per-channel gate filter, three capture modes, inverted bus and update strobe.
// Latency 0 (MODE 0 pass-through) or 1 cycle (MODE 1/2); no backpressure, inputs sampled every edge.
module lt_bank #(
   parameter int WIDTH = 4,
   parameter int CHANNELS = 4,
   parameter int MODE = 0,
   parameter int FILTER = 0,
   parameter logic [WIDTH-1:0] INIT = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       nG,
   input  logic [CHANNELS*WIDTH-1:0] D,
   output logic [CHANNELS*WIDTH-1:0] P,
   output logic [CHANNELS*WIDTH-1:0] N,
   output logic [CHANNELS-1:0]       upd
);

   localparam int CW = (FILTER > 0) ? $clog2(FILTER + 1) : 1;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic             ge;
      logic             gprev;
      logic             wr;
      logic             upd_r;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] d_c;

      assign d_c = D[c*WIDTH +: WIDTH];

      if (FILTER > 0) begin : g_filt
         logic          gf;
         logic [CW-1:0] fcnt;

         // A raw gate change must be seen on FILTER consecutive edges; any bounce restarts the count.
         always_ff @(posedge clk) begin
            if (reset) begin
               gf   <= 1'b1;
               fcnt <= '0;
            end else if (nG[c] == gf) begin
               fcnt <= '0;
            end else if (fcnt == CW'(FILTER - 1)) begin
               gf   <= nG[c];
               fcnt <= '0;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end
         assign ge = gf;
      end else begin : g_nofilt
         assign ge = nG[c];
      end

      // Open-edge capture writes only on the first open cycle; other modes write whenever open.
      assign wr = (MODE == 2) ? (!ge && gprev) : !ge;

      always_ff @(posedge clk) begin
         if (reset) begin
            q     <= INIT;
            gprev <= 1'b1;
            upd_r <= 1'b0;
         end else begin
            gprev <= ge;
            if (wr) q <= d_c;
            upd_r <= wr && (d_c != q);
         end
      end

      assign upd[c]                = upd_r;
      assign P[c*WIDTH +: WIDTH]   = (MODE == 0 && !ge) ? d_c : q;
   end

   assign N = ~P;

endmodule
